// File: rtl/viterbi_traceback_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// viterbi_pkg : shared constants, FSM encoding and trellis helper for the
//               K=3 Viterbi traceback path.
// Rev 1.0
// ============================================================================
package viterbi_pkg;

   localparam int NUM_STATES = 4;
   localparam int STATE_W    = 2;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] TRACE = 2'd1;
   localparam logic [1:0] EMIT  = 2'd2;

   // Trellis advances as next = {u, s[1]}, so stepping back recovers s[0] as the MSB.
   function automatic logic [STATE_W-1:0] pred_state(input logic [STATE_W-1:0] s,
                                                     input logic               surv);
      return {s[0], surv};
   endfunction

endpackage
`default_nettype wire

// File: rtl/viterbi_traceback_ctrl_mux.sv
`default_nettype none
// ============================================================================
// bit_mux4 : 4:1 single-bit multiplexer, select {d1,d0}.
// Rev 1.0
// ============================================================================
module bit_mux4 (
   input  logic in0,
   input  logic in1,
   input  logic in2,
   input  logic in3,
   input  logic d0,
   input  logic d1,
   output logic y
);

   always_comb begin
      y = in0;
      case ({d1, d0})
         2'd0:    y = in0;
         2'd1:    y = in1;
         2'd2:    y = in2;
         default: y = in3;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/viterbi_traceback_ctrl.sv
`default_nettype none
// ============================================================================
// viterbi_traceback_ctrl : walks the survivor memory back TB_LEN columns from
//                          the best end state and streams the bits oldest-first.
// Rev 1.0
// ============================================================================
module viterbi_traceback_ctrl
   import viterbi_pkg::*;
#(
   parameter int TB_LEN = 8,
   parameter int ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [STATE_W-1:0]    best_state,
   input  logic [ADDR_W-1:0]     end_addr,
   output logic                  mem_rd_en,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [NUM_STATES-1:0] mem_data,
   output logic [STATE_W-1:0]    sel,
   output logic                  dec_bit,
   output logic                  dec_valid,
   input  logic                  dec_ready,
   output logic                  dec_last,
   output logic                  busy
);

   localparam int                 c_cnt_w = $clog2(TB_LEN + 1);
   localparam logic [c_cnt_w-1:0] c_len   = c_cnt_w'(TB_LEN);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TB_LEN - 1);

   logic [1:0]         r_fsm;
   logic [c_cnt_w-1:0] r_cnt;
   logic [ADDR_W-1:0]  r_addr;
   logic [STATE_W-1:0] r_state;
   logic [TB_LEN-1:0]  r_buf;
   logic               w_surv;
   logic               w_rd;

   // Reads occupy TRACE cycles 0..TB_LEN-1; cycle TB_LEN only drains the last return.
   assign w_rd = (r_fsm == TRACE) && (r_cnt != c_len);

   bit_mux4 u_surv_mux (
      .in0 (mem_data[0]),
      .in1 (mem_data[1]),
      .in2 (mem_data[2]),
      .in3 (mem_data[3]),
      .d0  (r_state[0]),
      .d1  (r_state[1]),
      .y   (w_surv)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fsm   <= IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_state <= '0;
         r_buf   <= '0;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (start) begin
                  r_state <= best_state;
                  r_addr  <= end_addr;
                  r_cnt   <= '0;
                  r_fsm   <= TRACE;
               end
            end
            TRACE: begin
               if (w_rd) begin
                  r_addr <= r_addr - 1'b1;
               end
               // Newest column shifts in first, so the oldest bit lands in r_buf[0].
               if (r_cnt != '0) begin
                  r_buf   <= {r_buf[TB_LEN-2:0], r_state[1]};
                  r_state <= pred_state(r_state, w_surv);
               end
               if (r_cnt == c_len) begin
                  r_cnt <= '0;
                  r_fsm <= EMIT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            EMIT: begin
               if (dec_ready) begin
                  r_buf <= {1'b0, r_buf[TB_LEN-1:1]};
                  if (r_cnt == c_last) begin
                     r_cnt <= '0;
                     r_fsm <= IDLE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            default: r_fsm <= IDLE;
         endcase
      end
   end

   assign mem_rd_en = w_rd;
   assign mem_addr  = r_addr;
   assign sel       = r_state;
   assign dec_valid = (r_fsm == EMIT);
   assign dec_bit   = dec_valid & r_buf[0];
   assign dec_last  = dec_valid && (r_cnt == c_last);
   assign busy      = (r_fsm != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_viterbi_traceback_ctrl.sv
`default_nettype none
// ============================================================================
// tb_viterbi_traceback_ctrl : directed vector bench for viterbi_traceback_ctrl.
// Rev 1.0
// ============================================================================
module tb_viterbi_traceback_ctrl;
   import viterbi_pkg::*;

   localparam int TB_LEN = 8;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [1:0]        best_state = '0;
   logic [ADDR_W-1:0] end_addr = '0;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_data = '0;
   logic [1:0]        sel;
   logic              dec_bit;
   logic              dec_valid;
   logic              dec_ready = 1'b1;
   logic              dec_last;
   logic              busy;

   logic [3:0] mem [16];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] fill;
      int         hot_col;
      logic [3:0] hot_val;
      logic [1:0] best;
      logic [3:0] eaddr;
      logic [7:0] exp_bits;   // bit i = i-th emitted bit (oldest first)
      int         stall_idx;
      bit         pulse_start;
   } vec_t;

   vec_t vecs[6];

   viterbi_traceback_ctrl #(.TB_LEN(TB_LEN), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .best_state (best_state),
      .end_addr   (end_addr),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .sel        (sel),
      .dec_bit    (dec_bit),
      .dec_valid  (dec_valid),
      .dec_ready  (dec_ready),
      .dec_last   (dec_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Survivor memory with one cycle of read latency.
   always @(posedge clk) begin
      if (mem_rd_en) mem_data <= mem[mem_addr];
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, " mem_rd_en"}, int'(mem_rd_en), 0);
      chk({tag, " mem_addr"},  int'(mem_addr),  0);
      chk({tag, " sel"},       int'(sel),       0);
      chk({tag, " dec_bit"},   int'(dec_bit),   0);
      chk({tag, " dec_valid"}, int'(dec_valid), 0);
      chk({tag, " dec_last"},  int'(dec_last),  0);
      chk({tag, " busy"},      int'(busy),      0);
   endtask

   task automatic load_mem(input vec_t v);
      for (int c = 0; c < 16; c++) mem[c] = (c == v.hot_col) ? v.hot_val : v.fill;
   endtask

   task automatic run_vec(input vec_t v);
      int cyc, rd, nbits, stall;
      bit done, seen;
      load_mem(v);
      @(negedge clk);
      chk("idle busy", int'(busy), 0);
      start = 1'b1; best_state = v.best; end_addr = v.eaddr; dec_ready = 1'b1;
      cyc = 0; rd = 0; nbits = 0; stall = 0; done = 1'b0; seen = 1'b0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (v.pulse_start && (cyc == 4 || cyc == TB_LEN + 2)) begin
            start = 1'b1; best_state = ~v.best; end_addr = v.eaddr + 4'd3;
         end
         chk("busy", int'(busy), 1);
         if (cyc == 1) chk("sel start", int'(sel), int'(v.best));
         if (mem_rd_en) begin
            chk("mem_addr", int'(mem_addr), int'(4'(v.eaddr - 4'(rd))));
            rd++;
         end
         if (dec_valid) begin
            if (!seen) begin
               chk("latency", cyc, TB_LEN + 2);
               seen = 1'b1;
            end
            chk("dec_bit", int'(dec_bit), int'(v.exp_bits[nbits]));
            chk("dec_last", int'(dec_last), int'(nbits == TB_LEN - 1));
            if (nbits == v.stall_idx && stall < 3) begin
               dec_ready = 1'b0;
               stall++;
            end else begin
               dec_ready = 1'b1;
               if (nbits == TB_LEN - 1) begin
                  done = 1'b1;
                  if (v.pulse_start) start = 1'b1;
               end
               nbits++;
            end
         end
      end
      if (!done) chk("timeout", 0, 1);
      @(negedge clk);
      start = 1'b0; dec_ready = 1'b1;
      chk("post dec_valid", int'(dec_valid), 0);
      chk("post busy", int'(busy), 0);
      chk("read count", rd, TB_LEN);
      chk("bit count", nbits, TB_LEN);
      repeat (3) begin
         @(negedge clk);
         chk("no restart rd_en", int'(mem_rd_en), 0);
         chk("no restart busy", int'(busy), 0);
      end
   endtask

   initial begin
      //          fill   hot  hval   best   eaddr  exp    stall pulse
      vecs[0] = '{4'h0,  -1, 4'h0, 2'd3, 4'd7,  8'hC0, -1, 1'b0};
      vecs[1] = '{4'hF,  -1, 4'h0, 2'd0, 4'd7,  8'h3F, -1, 1'b0};
      vecs[2] = '{4'h0,  -1, 4'h0, 2'd3, 4'd2,  8'hC0, -1, 1'b0};
      vecs[3] = '{4'h0,   5, 4'hF, 2'd0, 4'd7,  8'h08,  4, 1'b0};
      vecs[4] = '{4'h5,  -1, 4'h0, 2'd2, 4'd0,  8'hAA, -1, 1'b1};
      vecs[5] = '{4'h8,  -1, 4'h0, 2'd1, 4'd15, 8'h40, -1, 1'b0};

      repeat (2) @(negedge clk);
      chk_idle_zero("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Reset in TRACE cycle 3 discards the traceback.
      load_mem(vecs[0]);
      @(negedge clk);
      start = 1'b1; best_state = 2'd3; end_addr = 4'd7;
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("mid-trace rd_en", int'(mem_rd_en), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk_idle_zero("mid reset");
      rst_n = 1'b1;
      repeat (TB_LEN + 4) begin
         @(negedge clk);
         chk("discard dec_valid", int'(dec_valid), 0);
         chk("discard busy", int'(busy), 0);
      end
      run_vec(vecs[1]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
